inst_queue: RTL and testbench
=============================

Name: inst_queue

Overview:
- Circular FIFO between fetch (F3) and issue (I). Holds up to DEPTH fetched instructions: {pc, instr, pred_taken}.
- Consumes the hazard unit's queue controls: flush_que, pred_flush_que and stallI.
- Produces the overflow indication that the hazard unit uses to stall the front end.
- Accepts up to 2 instructions per cycle and delivers up to 2 per cycle.

Parameters:
DEPTH, 16, number of entries; power of two, at least 4
PC_W, 32, pc width
INST_W, 32, instruction width

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
push_vld  in  2  per-slot push valid from F3; slot1 is valid only if slot0 is valid
push_pc  in  2*PC_W  slot pcs, slot0 in the low bits
push_inst  in  2*INST_W  slot instructions
push_pred  in  2  slot predicted-taken bits
pop_req  in  2  issue consumes head (bit0) and head+1 (bit1); bit1 is valid only if bit0 is valid
stall_pop  in  1  stallI from hazard; blocks all pops
flush  in  1  flush_que; full clear
pred_flush  in  1  pred_flush_que; clear stored entries, keep same-cycle push
out_vld  out  2  head / head+1 entries present
out_pc  out  2*PC_W  head entries' pcs
out_inst  out  2*INST_W  head entries' instructions
out_pred  out  2  head entries' predicted-taken bits
overflow  out  1  overflowI to hazard: fewer than 2 free slots
count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Storage: DEPTH-entry array. Head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is a separate register, range 0..DEPTH.
- Reset (resetn low, asynchronous):
  - head, tail and count go to 0.
  - out_vld = 0 and overflow = 0.
  - The array contents are not reset; out_* data is don't-care while out_vld is 0.
- Outputs are combinational from registered state (zero-latency read):
  - out_vld[0] = (count >= 1); out_vld[1] = (count >= 2).
  - A push becomes visible on the cycle after it is accepted. There is no same-cycle bypass.
- Pop (eff_pop): number of entries removed this cycle.
  - 0 if stall_pop, flush or pred_flush is high.
  - Otherwise popcount(pop_req & out_vld); pop_req bits without a matching out_vld are ignored.
  - head advances by eff_pop.
- Push (eff_push): number of entries written this cycle.
  - 0 if flush is high.
  - Otherwise popcount(push_vld), provided the free space (DEPTH - count + eff_pop) is at least that number.
  - Otherwise 0. All-or-nothing: a 2-entry push never splits.
  - Slot0 is written at tail and slot1 at tail+1 (wrapped).
- Same-cycle push and pop are allowed: count_next = count + eff_push - eff_pop. Free space counts the pops made in the same cycle.
- overflow = (DEPTH - count) < 2, from registered count.
  - F3 must hold push_vld while overflow is high. The hazard unit guarantees this by stalling.
  - If F3 pushes while overflow is high, the push is still governed by the space rule above.
- flush (priority 1):
  - Next cycle: head = tail = count = 0.
  - All pushes and pops in the flush cycle are discarded.
- pred_flush (priority 2, only when flush is low):
  - Stored entries are discarded.
  - The same-cycle push is written at index 0; head = 0, tail = eff_push, count = eff_push.
  - No pops occur.
- Write order: in a single-entry queue, an entry popped and a new entry pushed in the same cycle never alias, because write and read slots differ when count < DEPTH. When count = DEPTH, a push is accepted only if a pop frees space, and tail then equals the old head slot being vacated, which is legal.
- Invariant: count never exceeds DEPTH and never goes below 0. An assertion fires in simulation if it does.

Optional Feature:
INST_QUEUE_STATS_EN
- Defined:
  - Adds output ports hwm (occupancy high-water mark, $clog2(DEPTH)+1 bits) and ovf_cycles (32-bit count of cycles with overflow high).
  - Both reset asynchronously to 0.
  - Neither is cleared by flush or pred_flush.
  - ovf_cycles saturates at all-ones.
- Undefined: the ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, then push 2/cycle with pop_req = 0 and DEPTH = 16.
  - count = 14 after 7 cycles, and overflow goes high on the following cycle's output.
  - An 8th push of 2 succeeds (count 16); a 9th 2-entry push is rejected and count stays 16.
- Full queue (count 16), push_vld = 2'b11, pop_req = 2'b11, stall_pop = 0 -> count stays 16, the head advances by 2, and the new pcs appear at the tail.
- count 1 holding pc 0x100, pop_req = 2'b11 -> only 0x100 is popped; count = 0 and out_vld = 0.
- count 5, push_vld = 2'b01, pop_req = 2'b11, flush = 1 -> next cycle count = 0, out_vld = 0 and overflow = 0.
- count 5, push_vld = 2'b11 with pcs 0x200/0x204, pred_flush = 1 -> next cycle count = 2, out_pc slot0 = 0x200, slot1 = 0x204.
- count 3, stall_pop = 1, pop_req = 2'b11 for 4 cycles -> count holds at 3 and the head pc is unchanged. Then drop resetn asynchronously mid-cycle -> count = 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/inst_queue.sv
// inst_queue: circular instruction FIFO between fetch stage F3 and issue.
// Accepts up to two {pc, instr, pred_taken} entries per cycle and presents
// the two oldest entries combinationally from registered state.
// Optional statistics (high-water mark, overflow cycle count) are compiled
// in when INST_QUEUE_STATS_EN is defined.
module inst_queue #(
    parameter int DEPTH  = 16,
    parameter int PC_W   = 32,
    parameter int INST_W = 32
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [1:0]                  push_vld,
    input  logic [2*PC_W-1:0]           push_pc,
    input  logic [2*INST_W-1:0]         push_inst,
    input  logic [1:0]                  push_pred,
    input  logic [1:0]                  pop_req,
    input  logic                        stall_pop,
    input  logic                        flush,
    input  logic                        pred_flush,
    output logic [1:0]                  out_vld,
    output logic [2*PC_W-1:0]           out_pc,
    output logic [2*INST_W-1:0]         out_inst,
    output logic [1:0]                  out_pred,
    output logic                        overflow,
    output logic [$clog2(DEPTH):0]      count
`ifdef INST_QUEUE_STATS_EN
    ,
    output logic [$clog2(DEPTH):0]      hwm,
    output logic [31:0]                 ovf_cycles
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]   DEPTH_X   = (CNT_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] OVF_LIMIT = CNT_W'(DEPTH - 2);

    // Entry storage; contents are never reset, validity comes from countQ.
    logic [PC_W-1:0]   pcMem   [DEPTH];
    logic [INST_W-1:0] instMem [DEPTH];
    logic [DEPTH-1:0]  predMem;

    logic [PTR_W-1:0]  headPtr;
    logic [PTR_W-1:0]  tailPtr;
    logic [CNT_W-1:0]  countQ;

    logic [PTR_W-1:0]  headPtr1;
    logic [1:0]        outVld;
    logic [1:0]        effPop;
    logic [1:0]        effPush;
    logic [1:0]        pushReq;
    logic [CNT_W:0]    freeSpace;
    logic [CNT_W:0]    countSum;
    logic [PTR_W-1:0]  wrBase;
    logic [PTR_W-1:0]  wrBase1;

    function automatic logic [1:0] popCount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

    // Pop/push arbitration: pops first, so a full queue can take a push
    // in the same cycle it drains; pushes are all-or-nothing.
    always_comb begin
        headPtr1  = headPtr + PTR_W'(1);
        outVld    = {countQ >= CNT_W'(2), countQ >= CNT_W'(1)};
        effPop    = 2'd0;
        if (!(stall_pop || flush || pred_flush)) begin
            effPop = popCount2(pop_req & outVld);
        end
        pushReq   = popCount2(push_vld);
        freeSpace = DEPTH_X - {1'b0, countQ} + {{(CNT_W-1){1'b0}}, effPop};
        effPush   = 2'd0;
        if (!flush && (freeSpace >= {{(CNT_W-1){1'b0}}, pushReq})) begin
            effPush = pushReq;
        end
        // A predicted-path flush restarts the ring at slot 0.
        wrBase    = pred_flush ? '0 : tailPtr;
        wrBase1   = wrBase + PTR_W'(1);
        countSum  = {1'b0, countQ} + {{(CNT_W-1){1'b0}}, effPush}
                                   - {{(CNT_W-1){1'b0}}, effPop};
    end

    // Pointer and occupancy registers; flush beats pred_flush beats normal flow.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            headPtr <= '0;
            tailPtr <= '0;
            countQ  <= '0;
        end else if (flush) begin
            headPtr <= '0;
            tailPtr <= '0;
            countQ  <= '0;
        end else if (pred_flush) begin
            headPtr <= '0;
            tailPtr <= PTR_W'(effPush);
            countQ  <= CNT_W'(effPush);
        end else begin
            headPtr <= headPtr + PTR_W'(effPop);
            tailPtr <= tailPtr + PTR_W'(effPush);
            countQ  <= countSum[CNT_W-1:0];
        end
    end

    // Entry writes; slot0 lands at the write base, slot1 right after it.
    always_ff @(posedge clk) begin
        if (effPush != 2'd0) begin
            pcMem[wrBase]   <= push_pc[PC_W-1:0];
            instMem[wrBase] <= push_inst[INST_W-1:0];
            predMem[wrBase] <= push_pred[0];
        end
        if (effPush == 2'd2) begin
            pcMem[wrBase1]   <= push_pc[2*PC_W-1:PC_W];
            instMem[wrBase1] <= push_inst[2*INST_W-1:INST_W];
            predMem[wrBase1] <= push_pred[1];
        end
    end

    // Zero-latency read of the two oldest entries.
    always_comb begin
        out_vld  = outVld;
        out_pc   = {pcMem[headPtr1], pcMem[headPtr]};
        out_inst = {instMem[headPtr1], instMem[headPtr]};
        out_pred = {predMem[headPtr1], predMem[headPtr]};
        overflow = (countQ > OVF_LIMIT);
        count    = countQ;
    end

    countRange: assert property (@(posedge clk) disable iff (!resetn)
        (countSum <= DEPTH_X));

`ifdef INST_QUEUE_STATS_EN
    // Statistics survive flushes; only reset clears them.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hwm        <= '0;
            ovf_cycles <= '0;
        end else begin
            if (countQ > hwm) begin
                hwm <= countQ;
            end
            if (overflow && (ovf_cycles != 32'hFFFF_FFFF)) begin
                ovf_cycles <= ovf_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed stimulus for inst_queue with a queue-based
// reference model checked every cycle, plus literal spot checks.
module tb_inst_queue;

    localparam int DEPTH  = 16;
    localparam int PC_W   = 32;
    localparam int INST_W = 32;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic                  clk = 1'b0;
    logic                  resetn = 1'b1;
    logic [1:0]            push_vld = '0;
    logic [2*PC_W-1:0]     push_pc = '0;
    logic [2*INST_W-1:0]   push_inst = '0;
    logic [1:0]            push_pred = '0;
    logic [1:0]            pop_req = '0;
    logic                  stall_pop = 1'b0;
    logic                  flush = 1'b0;
    logic                  pred_flush = 1'b0;
    logic [1:0]            out_vld;
    logic [2*PC_W-1:0]     out_pc;
    logic [2*INST_W-1:0]   out_inst;
    logic [1:0]            out_pred;
    logic                  overflow;
    logic [CNT_W-1:0]      count;
`ifdef INST_QUEUE_STATS_EN
    logic [CNT_W-1:0]      hwm;
    logic [31:0]           ovf_cycles;
`endif

    int tests = 0;
    int fails = 0;

    inst_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) dut (
        .clk(clk), .resetn(resetn),
        .push_vld(push_vld), .push_pc(push_pc), .push_inst(push_inst),
        .push_pred(push_pred), .pop_req(pop_req), .stall_pop(stall_pop),
        .flush(flush), .pred_flush(pred_flush),
        .out_vld(out_vld), .out_pc(out_pc), .out_inst(out_inst),
        .out_pred(out_pred), .overflow(overflow), .count(count)
`ifdef INST_QUEUE_STATS_EN
        , .hwm(hwm), .ovf_cycles(ovf_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of entries updated by the rules.
    typedef struct {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic              pred;
    } ent_t;
    ent_t mq[$];

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mq.delete();
        end else begin
            int pops;
            int npush;
            int freeS;
            ent_t e0;
            ent_t e1;
            pops = 0;
            if (!(stall_pop || flush || pred_flush))
                for (int i = 0; i < 2; i++)
                    if (pop_req[i] && (mq.size() > i)) pops++;
            npush = int'(push_vld[0]) + int'(push_vld[1]);
            freeS = DEPTH - mq.size() + pops;
            e0 = '{push_pc[PC_W-1:0], push_inst[INST_W-1:0], push_pred[0]};
            e1 = '{push_pc[2*PC_W-1:PC_W], push_inst[2*INST_W-1:INST_W], push_pred[1]};
            if (flush) begin
                mq.delete();
            end else begin
                if (pred_flush) mq.delete();
                else repeat (pops) void'(mq.pop_front());
                if ((npush > 0) && (npush <= freeS)) begin
                    mq.push_back(e0);
                    if (npush == 2) mq.push_back(e1);
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        int sz;
        sz = mq.size();
        check("model_count", 64'(count), 64'(sz));
        check("model_out_vld", 64'(out_vld), 64'({sz >= 2, sz >= 1}));
        check("model_overflow", 64'(overflow), 64'((DEPTH - sz) < 2));
        for (int i = 0; i < 2; i++) begin
            if (sz > i) begin
                check("model_pc", 64'(out_pc[i*PC_W +: PC_W]), 64'(mq[i].pc));
                check("model_inst", 64'(out_inst[i*INST_W +: INST_W]), 64'(mq[i].inst));
                check("model_pred", 64'(out_pred[i]), 64'(mq[i].pred));
            end
        end
    end

    task automatic drive(input logic [1:0] pv, input logic [31:0] pc0, input logic [31:0] pc1,
                         input logic [1:0] pr, input logic [1:0] pop,
                         input logic st, input logic fl, input logic pf);
        push_vld   = pv;
        push_pc    = {pc1, pc0};
        push_inst  = {~pc1, ~pc0};
        push_pred  = pr;
        pop_req    = pop;
        stall_pop  = st;
        flush      = fl;
        pred_flush = pf;
        @(posedge clk);
        #1;
    endtask

    task automatic fill5();
        drive(2'b11, 32'h400, 32'h404, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        drive(2'b11, 32'h408, 32'h40C, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        drive(2'b01, 32'h410, 32'h0,   2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_count", 64'(count), 64'd0);
        check("reset_out_vld", 64'(out_vld), 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);
        resetn = 1'b1;

        for (int k = 0; k < 7; k++)
            drive(2'b11, 32'h1000 + 32'(8*k), 32'h1004 + 32'(8*k), 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        check("fill7_count", 64'(count), 64'd14);
        check("fill7_overflow", 64'(overflow), 64'd0);
        check("fill7_head_pc", 64'(out_pc[31:0]), 64'h1000);

        drive(2'b11, 32'h1038, 32'h103C, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        check("fill8_count", 64'(count), 64'd16);
        check("fill8_overflow", 64'(overflow), 64'd1);

        drive(2'b11, 32'h1040, 32'h1044, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        check("reject_count", 64'(count), 64'd16);
        check("reject_head_pc", 64'(out_pc[31:0]), 64'h1000);

        drive(2'b11, 32'h3000, 32'h3004, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0);
        check("full_pushpop_count", 64'(count), 64'd16);
        check("full_pushpop_head", 64'(out_pc), 64'h0000100C_00001008);

        repeat (7) drive(2'b00, 32'h0, 32'h0, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0);
        check("drain_count", 64'(count), 64'd2);
        check("drain_tail_pcs", 64'(out_pc), 64'h00003004_00003000);

        drive(2'b00, 32'h0, 32'h0, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0);
        check("empty_count", 64'(count), 64'd0);

        drive(2'b01, 32'h100, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        check("one_count", 64'(count), 64'd1);
        check("one_pc", 64'(out_pc[31:0]), 64'h100);
        drive(2'b00, 32'h0, 32'h0, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0);
        check("pop_one_count", 64'(count), 64'd0);
        check("pop_one_out_vld", 64'(out_vld), 64'd0);

        fill5();
        check("five_count", 64'(count), 64'd5);
        drive(2'b01, 32'h500, 32'h0, 2'b00, 2'b11, 1'b0, 1'b1, 1'b0);
        check("flush_count", 64'(count), 64'd0);
        check("flush_out_vld", 64'(out_vld), 64'd0);
        check("flush_overflow", 64'(overflow), 64'd0);

        fill5();
        drive(2'b11, 32'h200, 32'h204, 2'b10, 2'b11, 1'b0, 1'b0, 1'b1);
        check("pflush_count", 64'(count), 64'd2);
        check("pflush_pcs", 64'(out_pc), 64'h00000204_00000200);
        check("pflush_pred", 64'(out_pred), 64'd2);

        drive(2'b01, 32'h208, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        check("three_count", 64'(count), 64'd3);
        repeat (4) drive(2'b00, 32'h0, 32'h0, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0);
        check("stall_count", 64'(count), 64'd3);
        check("stall_head_pc", 64'(out_pc[31:0]), 64'h200);

        #1 resetn = 1'b0;
        #1;
        check("async_reset_count", 64'(count), 64'd0);
        check("async_reset_out_vld", 64'(out_vld), 64'd0);
        check("async_reset_overflow", 64'(overflow), 64'd0);

        drive(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        resetn = 1'b1;
        drive(2'b11, 32'h600, 32'h604, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        check("post_reset_pcs", 64'(out_pc), 64'h00000604_00000600);
        drive(2'b00, 32'h0, 32'h0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
        check("post_reset_pop1", 64'(out_pc[31:0]), 64'h604);
        drive(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
